// File: rtl/fir_out_decim.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_decim
// Function : FIR output shaper. Keeps every DECIM-th accepted sample, rounds
//            it down by SHIFT bits, saturates it to OUT_WIDTH bits and queues
//            it in a small FIFO with a valid/ready consumer interface.
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_decim #(
  parameter int IN_WIDTH  = 25,
  parameter int OUT_WIDTH = 12,
  parameter int SHIFT     = 7,
  parameter int DECIM     = 4,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        sat_pulse,
  output logic                        drop_sticky,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Half an LSB of the shifted result; collapses to zero when SHIFT is 0.
  localparam logic signed [IN_WIDTH:0] RND =
    ({{IN_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1;

  // Saturation limits expressed at the stage-1 width for a direct compare.
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // Phase counter
  logic [PH_W-1:0] phase_q, phase_d;
  logic            keep;

  // Stage 1: rounded and shifted value, one bit wider than the input
  logic                      s1_valid_q, s1_valid_d;
  logic signed [IN_WIDTH:0]  s1_data_q, s1_data_d;
  logic signed [IN_WIDTH:0]  rnd_sum;

  // Stage 2: saturated value and clip flag
  logic                        s2_valid_q, s2_valid_d;
  logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                        sat_q, sat_d;

  // FIFO state
  logic signed [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        drop_q, drop_d;
  logic                        fifo_full;
  logic                        push;
  logic                        pop;

  // Decimation phase: only the sample accepted at phase 0 is kept.
  always_comb begin
    keep    = in_valid && (phase_q == '0);
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  // Round-half-up then arithmetic shift; the extra bit prevents wrap.
  always_comb begin
    rnd_sum    = $signed({in_data[IN_WIDTH-1], in_data}) + RND;
    s1_data_d  = rnd_sum >>> SHIFT;
    s1_valid_d = keep;
  end

  // Clip the stage-1 value into the signed output range.
  always_comb begin
    s2_valid_d = s1_valid_q;
    sat_d      = 1'b0;
    s2_data_d  = s1_data_q[OUT_WIDTH-1:0];
    if (s1_data_q > SAT_MAX) begin
      s2_data_d = SAT_MAX[OUT_WIDTH-1:0];
      sat_d     = s1_valid_q;
    end else if (s1_data_q < SAT_MIN) begin
      s2_data_d = SAT_MIN[OUT_WIDTH-1:0];
      sat_d     = s1_valid_q;
    end
  end

  // FIFO control: a write into a full FIFO succeeds only alongside a pop.
  always_comb begin
    fifo_full = (count_q == CNT_FULL);
    pop       = (count_q != '0) && out_ready;
    push      = s2_valid_q && (!fifo_full || pop);
    drop_d    = drop_q || (s2_valid_q && fifo_full && !pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; clr wipes every in-flight and stored sample at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      sat_q      <= sat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are only observable through count-qualified reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  // Output view: head data is forced to zero whenever the FIFO is empty.
  always_comb begin
    out_valid   = (count_q != '0);
    out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    sat_pulse   = sat_q;
    drop_sticky = drop_q;
    fifo_count  = count_q;
  end

endmodule
`default_nettype wire
